fsa_scan_ctl: RTL and testbench
===============================

Name: fsa_scan_ctl

Overview:
- Sequences readout of one fsa result-buffer read port (r_sof/r_en/r_addr/r_data).
- Per scan: locks a buffer with r_sof, then reads rows 0..height-1 and emits them as one AXI-Stream packet (tuser on first beat, tlast on last).
- Scans start from a programmable period timer or an external trigger pulse.
- Drives an fsync pulse aligned with each scan start for downstream overlay/blender logic.

Parameters:
- C_IMG_HW, 12, width of height input and row counter
- BR_AW, 12, read address width (BR_AW >= C_IMG_HW)
- BR_DW, 32, read data width
- C_PERIOD_W, 16, width of the period register

Ports:
- clk  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous reset, active-high
- height  in  C_IMG_HW  rows per scan; sampled at scan start
- period  in  C_PERIOD_W  auto-scan period in cycles; 0 disables the timer
- trigger  in  1  single-cycle scan request
- r_sof  out  1  one-cycle buffer lock/start pulse to fsa
- r_en  out  1  read enable
- r_addr  out  BR_AW  row address, zero-extended
- r_data  in  BR_DW  read data, valid exactly 1 cycle after r_en
- m_axis_fsync  out  1  one-cycle pulse, same cycle as r_sof
- m_axis_tvalid  out  1  stream valid
- m_axis_tdata  out  BR_DW (see Optional Feature)  row result
- m_axis_tuser  out  1  first row of scan
- m_axis_tlast  out  1  last row of scan
- m_axis_tready  in  1  stream ready
- busy  out  1  high in any state except IDLE
- overrun  out  1  sticky; set when a request arrives while one is already pending

Behaviour:
- Reset (sync, active-high), effective on the next edge:
  - Outputs r_sof, r_en, m_axis_fsync, m_axis_tvalid, tuser, tlast, busy, overrun = 0; r_addr = 0.
  - Internal state: timer = 0, pending = 0, buffer empty, FSM = IDLE.
  - Reset mid-scan abandons the scan; no further beats are emitted.
- Timer:
  - If period != 0, counts 0..period-1. At period-1 it wraps to 0 and raises a request.
  - If period == 0, the timer is held at 0.
  - A change of period takes effect on the next wrap or when the count reaches the new value.
- Requests:
  - Sources are the timer wrap OR trigger; simultaneous requests count as one.
  - A request sets pending (one-deep).
  - If pending is already 1 and is not being consumed in the same cycle, overrun <= 1. Overrun clears only on reset.
- FSM states:
  - IDLE -> START when pending = 1.
  - START (1 cycle):
    - r_sof = 1 and m_axis_fsync = 1.
    - Latch hgt = height; clear pending (a request arriving in the same cycle re-sets it).
    - If hgt == 0 go to IDLE: no reads, no beats. Otherwise go to READ with row = 0.
  - READ:
    - Assert r_en with r_addr = row when (buffer occupancy + reads in flight) < 2.
    - Increment row per issued read.
    - After issuing row hgt-1, go to DRAIN.
  - DRAIN: go to IDLE when the buffer is empty and no read is in flight.
- Read datapath:
  - r_data is captured the cycle after r_en into a 2-entry FIFO, together with tuser = (row == 0) and tlast = (row == hgt-1).
  - With hgt == 1, the single beat has tuser = tlast = 1.
- Stream:
  - m_axis_tvalid is driven from FIFO non-empty.
  - Pop on tvalid & tready.
  - tvalid, tdata, tuser and tlast hold stable while tvalid & !tready.
  - A push and a pop in the same cycle are both legal.
  - Throughput is 1 beat/cycle with tready held high.
  - Latency: first beat tvalid appears 3 cycles after the START cycle (START, r_en, capture, visible).
- Ordering: beats leave in row order; no beat of scan N+1 precedes the tlast of scan N.

Optional Feature:
- FSA_SCAN_CTL_ROWIDX_EN defined:
  - m_axis_tdata width becomes C_IMG_HW + BR_DW.
  - Upper C_IMG_HW bits carry the row index; lower BR_DW bits carry r_data.
- Undefined: m_axis_tdata is BR_DW bits, r_data only.

Test Plan:
- period=0, height=4, trigger pulse, tready=1:
  - r_sof and fsync pulse 1 cycle; r_addr 0,1,2,3 on consecutive cycles.
  - 4 beats, tuser on beat 0, tlast on beat 3; busy falls after the last pop.
- period=100, height=2, trigger never:
  - Scans start every 100 cycles; each scan is 2 beats; overrun stays 0.
- height=5, tready toggling randomly 50%:
  - No beat lost or duplicated; data equals r_data of rows 0..4 in order.
  - At most 2 reads outstanding plus buffered at any time.
- height=0, trigger:
  - r_sof/fsync pulse, zero r_en, zero beats; back in IDLE after 1 cycle.
- height=8, tready=0, trigger pulsed 3 times during the scan:
  - After a single pending request, overrun=1.
  - When tready is released: 8 beats, then exactly one further scan.
- reset asserted mid-READ (row=3), then trigger after reset released:
  - All outputs 0 the cycle after reset.
  - The new scan starts at r_addr=0 with tuser on its first beat.

Source files
------------

// File: rtl/fsa_scan_ctl.sv
// fsa_scan_ctl: sequences readout of one fsa result-buffer read port.
// Each scan locks a buffer (r_sof), reads rows 0..height-1 and emits them
// as one AXI-Stream packet (tuser on first beat, tlast on last).
// Scans start from a programmable period timer or an external trigger.
// Optional build macro FSA_SCAN_CTL_ROWIDX_EN: prefixes each beat's tdata
// with the row index (tdata = {row, r_data}).
module fsa_scan_ctl #(
    parameter int C_IMG_HW   = 12,
    parameter int BR_AW      = 12,
    parameter int BR_DW      = 32,
    parameter int C_PERIOD_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [C_IMG_HW-1:0]   height,
    input  logic [C_PERIOD_W-1:0] period,
    input  logic                  trigger,
    output logic                  r_sof,
    output logic                  r_en,
    output logic [BR_AW-1:0]      r_addr,
    input  logic [BR_DW-1:0]      r_data,
    output logic                  m_axis_fsync,
    output logic                  m_axis_tvalid,
`ifdef FSA_SCAN_CTL_ROWIDX_EN
    output logic [C_IMG_HW+BR_DW-1:0] m_axis_tdata,
`else
    output logic [BR_DW-1:0]      m_axis_tdata,
`endif
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  overrun
);

`ifdef FSA_SCAN_CTL_ROWIDX_EN
    localparam int TD_W = C_IMG_HW + BR_DW;
`else
    localparam int TD_W = BR_DW;
`endif

    typedef enum logic [1:0] {S_IDLE, S_START, S_READ, S_DRAIN} state_t;

    typedef struct packed {
        logic [TD_W-1:0] data;
        logic            user;
        logic            last;
    } beat_t;

    state_t                r_state, w_state_nxt;
    logic [C_PERIOD_W-1:0] r_timer;
    logic                  w_wrap, w_req, w_consume;
    logic                  r_pending, r_overrun;
    logic [C_IMG_HW-1:0]   r_hgt, r_row, r_rd_row;
    logic                  r_rd_vld;
    beat_t                 r_fifo [2];
    logic                  r_wptr, r_rptr;
    logic [1:0]            r_cnt;
    logic                  w_push, w_pop;
    logic [1:0]            w_occ;
    logic                  w_room;
    logic                  w_last_issue;
    logic                  w_sof, w_en, w_busy;
    beat_t                 w_beat;

    // A period at or below the current count wraps at once, so a shortened
    // period takes effect without waiting for a full rollover.
    assign w_wrap    = (period != '0) && (r_timer >= period - C_PERIOD_W'(1));
    assign w_req     = w_wrap | trigger;
    assign w_consume = (r_state == S_START);

    // Free-running period timer; held at zero while disabled.
    always_ff @(posedge clk) begin
        if (reset)               r_timer <= '0;
        else if (period == '0)   r_timer <= '0;
        else if (w_wrap)         r_timer <= '0;
        else                     r_timer <= r_timer + C_PERIOD_W'(1);
    end

    // One-deep request latch plus sticky overrun on a dropped request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_req)          r_pending <= 1'b1;
            else if (w_consume) r_pending <= 1'b0;
            if (w_req && r_pending && !w_consume) r_overrun <= 1'b1;
        end
    end

    // Pop frees its slot in the same cycle, so the read credit counts the
    // post-pop occupancy; this keeps 1 beat/cycle with tready held high.
    assign w_pop  = (r_cnt != 2'd0) && m_axis_tready;
    assign w_push = r_rd_vld;
    assign w_occ  = r_cnt - {1'b0, w_pop};
    assign w_room = ({1'b0, w_occ} + {2'b00, r_rd_vld}) < 3'd2;
    assign w_last_issue = (r_row == r_hgt - C_IMG_HW'(1));

    // Scan FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Scan FSM next state and strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_sof       = 1'b0;
        w_en        = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (r_pending) w_state_nxt = S_START;
            end
            S_START: begin
                w_sof       = 1'b1;
                w_state_nxt = (height == '0) ? S_IDLE : S_READ;
            end
            S_READ: begin
                if (w_room) begin
                    w_en = 1'b1;
                    if (w_last_issue) w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_occ == 2'd0 && !r_rd_vld) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Scan height latch and row address counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hgt <= '0;
            r_row <= '0;
        end else if (r_state == S_START) begin
            r_hgt <= height;
            r_row <= '0;
        end else if (w_en) begin
            r_row <= r_row + C_IMG_HW'(1);
        end
    end

    // One-cycle read latency tracker: r_data is valid the cycle after r_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_vld <= 1'b0;
            r_rd_row <= '0;
        end else begin
            r_rd_vld <= w_en;
            if (w_en) r_rd_row <= r_row;
        end
    end

`ifdef FSA_SCAN_CTL_ROWIDX_EN
    assign w_beat.data = {r_rd_row, r_data};
`else
    assign w_beat.data = r_data;
`endif
    assign w_beat.user = (r_rd_row == '0);
    assign w_beat.last = (r_rd_row == r_hgt - C_IMG_HW'(1));

    // Two-entry output FIFO; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
            for (int i = 0; i < 2; i++) r_fifo[i] <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_beat;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign m_axis_tvalid = (r_cnt != 2'd0);
    assign m_axis_tdata  = r_fifo[r_rptr].data;
    assign m_axis_tuser  = m_axis_tvalid & r_fifo[r_rptr].user;
    assign m_axis_tlast  = m_axis_tvalid & r_fifo[r_rptr].last;

    assign r_sof        = w_sof;
    assign m_axis_fsync = w_sof;
    assign r_en         = w_en;
    assign r_addr       = BR_AW'(r_row);
    assign busy         = w_busy;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_fsa_scan_ctl.sv
// tb_fsa_scan_ctl: scoreboard bench for fsa_scan_ctl. Stimulus pushes the
// expected beats of each scan; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_fsa_scan_ctl;
    localparam int C_IMG_HW   = 12;
    localparam int BR_AW      = 12;
    localparam int BR_DW      = 32;
    localparam int C_PERIOD_W = 16;
`ifdef FSA_SCAN_CTL_ROWIDX_EN
    localparam int TDW = C_IMG_HW + BR_DW;
`else
    localparam int TDW = BR_DW;
`endif

    typedef struct {
        logic [TDW-1:0] d;
        logic           u;
        logic           l;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [C_IMG_HW-1:0]   height = '0;
    logic [C_PERIOD_W-1:0] period = '0;
    logic                  trigger = 1'b0;
    logic                  r_sof, r_en;
    logic [BR_AW-1:0]      r_addr;
    logic [BR_DW-1:0]      r_data = '0;
    logic                  m_axis_fsync, m_axis_tvalid, m_axis_tuser, m_axis_tlast;
    logic [TDW-1:0]        m_axis_tdata;
    logic                  m_axis_tready = 1'b1;
    logic                  busy, overrun;

    logic [7:0] salt = 8'd0;
    logic       rnd_rdy = 1'b0;
    logic       rdy_fix = 1'b1;

    int   total = 0;
    int   bad = 0;
    int   sof_cnt = 0;
    int   iss = 0;
    int   pops = 0;
    exp_t sb[$];
    logic           prev_stall = 1'b0;
    logic [TDW+1:0] prev_pl = '0;

    fsa_scan_ctl #(
        .C_IMG_HW(C_IMG_HW), .BR_AW(BR_AW), .BR_DW(BR_DW), .C_PERIOD_W(C_PERIOD_W)
    ) dut (
        .clk(clk), .reset(reset), .height(height), .period(period),
        .trigger(trigger), .r_sof(r_sof), .r_en(r_en), .r_addr(r_addr),
        .r_data(r_data), .m_axis_fsync(m_axis_fsync),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mdat(input logic [7:0] s, input logic [11:0] a);
        return {8'hC3, s, 4'h5, a};
    endfunction

    // Result buffer model: data one cycle after r_en.
    always @(posedge clk) if (r_en) r_data <= mdat(salt, r_addr);

    // tready driver: fixed level or random 50%.
    always @(posedge clk) begin
        #1;
        m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_fix;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_scan(input logic [7:0] s, input int h);
        exp_t e;
        for (int r = 0; r < h; r++) begin
`ifdef FSA_SCAN_CTL_ROWIDX_EN
            e.d = {C_IMG_HW'(r), mdat(s, 12'(r))};
`else
            e.d = mdat(s, 12'(r));
`endif
            e.u = (r == 0);
            e.l = (r == h - 1);
            sb.push_back(e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse;
        trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
    endtask

    task automatic wait_empty(input string nm, input int n);
        for (int i = 0; i < n && sb.size() != 0; i++) @(negedge clk);
        chk(nm, 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_idle(input string nm, input int n);
        for (int i = 0; i < n && busy; i++) @(negedge clk);
        chk(nm, 64'(busy), 64'd0);
    endtask

    // Monitor: scoreboard pops, hold stability, read credit, fsync alignment.
    always @(negedge clk) begin
        exp_t e;
        int   pn;
        if (reset) begin
            iss = 0; pops = 0; prev_stall = 1'b0;
        end else begin
            if (r_sof) sof_cnt++;
            if (r_sof || m_axis_fsync) chk("fsync_align", 64'(m_axis_fsync), 64'(r_sof));
            if (prev_stall)
                chk("hold_stable", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast}),
                    64'({1'b1, prev_pl}));
            pn = (m_axis_tvalid && m_axis_tready) ? 1 : 0;
            if (r_en) chk("outstanding_le2", 64'((iss - pops - pn + 1) <= 2), 64'd1);
            if (pn == 1) begin
                pops++;
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 64'(m_axis_tdata), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("tdata", 64'(m_axis_tdata), 64'(e.d));
                    chk("tuser", 64'(m_axis_tuser), 64'(e.u));
                    chk("tlast", 64'(m_axis_tlast), 64'(e.l));
                end
            end
            if (r_en) iss++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_pl    = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, expected test end");
        $fatal(1);
    end

    initial begin
        int sof_i, first_en, nen, first_v, nsof, lst, s0, nv;
        logic b7, b8, b1, b2;

        // reset state
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_sof",   64'(r_sof), 0);
        chk("rst_fsync", 64'(m_axis_fsync), 0);
        chk("rst_en",    64'(r_en), 0);
        chk("rst_addr",  64'(r_addr), 0);
        chk("rst_valid", 64'(m_axis_tvalid), 0);
        chk("rst_user_last", 64'({m_axis_tuser, m_axis_tlast}), 0);
        chk("rst_busy",  64'(busy), 0);
        chk("rst_ovr",   64'(overrun), 0);

        // basic scan: height 4, trigger, tready high
        tick(1);
        salt = 8'd1; height = 12'd4; push_scan(8'd1, 4);
        pulse();
        sof_i = -1; first_en = -1; nen = 0; first_v = -1; nsof = 0; b7 = 0; b8 = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (r_sof) begin nsof++; sof_i = i; end
            if (r_en) begin
                if (first_en < 0) first_en = i;
                nen++;
                chk("p1_addr_seq", 64'(r_addr), 64'(i - 2));
            end
            if (m_axis_tvalid && first_v < 0) first_v = i;
            if (i == 7) b7 = busy;
            if (i == 8) b8 = busy;
        end
        chk("p1_sof_cycle", 64'(sof_i), 64'd1);
        chk("p1_sof_count", 64'(nsof), 64'd1);
        chk("p1_first_en", 64'(first_en), 64'd2);
        chk("p1_en_count", 64'(nen), 64'd4);
        chk("p1_latency", 64'(first_v), 64'd4);
        chk("p1_busy_lastpop", 64'(b7), 64'd1);
        chk("p1_busy_after", 64'(b8), 64'd0);
        wait_empty("p1_drain", 20);

        // timer scans: period 100, height 2
        tick(2);
        salt = 8'd2; height = 12'd2;
        push_scan(8'd2, 2); push_scan(8'd2, 2); push_scan(8'd2, 2);
        period = 16'd100;
        sof_i = -1; lst = -1; nsof = 0;
        for (int i = 0; i < 360; i++) begin
            @(negedge clk);
            if (r_sof) begin
                if (sof_i < 0) sof_i = i;
                lst = i; nsof++;
            end
        end
        period = 16'd0;
        chk("p2_first_sof", 64'(sof_i), 64'd101);
        chk("p2_last_sof", 64'(lst), 64'd301);
        chk("p2_sof_count", 64'(nsof), 64'd3);
        wait_empty("p2_drain", 40);
        chk("p2_overrun", 64'(overrun), 0);

        // random backpressure: height 5
        tick(2);
        salt = 8'd3; height = 12'd5; push_scan(8'd3, 5);
        rnd_rdy = 1'b1;
        pulse();
        wait_empty("p3_drain", 300);
        rnd_rdy = 1'b0; rdy_fix = 1'b1;
        wait_idle("p3_idle", 20);

        // zero height scan
        tick(2);
        salt = 8'd4; height = 12'd0;
        s0 = sof_cnt;
        pulse();
        nen = 0; nv = 0; b1 = 0; b2 = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (r_en) nen++;
            if (m_axis_tvalid) nv++;
            if (i == 1) b1 = busy;
            if (i == 2) b2 = busy;
        end
        chk("p4_sof_count", 64'(sof_cnt - s0), 64'd1);
        chk("p4_no_reads", 64'(nen), 0);
        chk("p4_no_beats", 64'(nv), 0);
        chk("p4_busy_start", 64'(b1), 64'd1);
        chk("p4_busy_idle", 64'(b2), 64'd0);

        // overrun: height 8, tready low, extra triggers during the scan
        tick(1);
        rdy_fix = 1'b0;
        tick(2);
        salt = 8'd5; height = 12'd8;
        push_scan(8'd5, 8); push_scan(8'd5, 8);
        s0 = sof_cnt;
        pulse();
        tick(5);
        pulse();
        tick(1);
        chk("p5_ovr_one_pending", 64'(overrun), 0);
        pulse();
        tick(2);
        pulse();
        tick(20);
        chk("p5_overrun", 64'(overrun), 64'd1);
        chk("p5_one_scan_so_far", 64'(sof_cnt - s0), 64'd1);
        chk("p5_busy_stalled", 64'(busy), 64'd1);
        rdy_fix = 1'b1;
        wait_empty("p5_drain", 300);
        wait_idle("p5_idle", 20);
        tick(10);
        chk("p5_two_scans", 64'(sof_cnt - s0), 64'd2);
        chk("p5_overrun_sticky", 64'(overrun), 64'd1);

        // reset mid-READ, then a fresh scan
        salt = 8'd6; height = 12'd8; push_scan(8'd6, 8);
        pulse();
        nen = 0;
        for (int i = 0; i < 20 && !(r_en && r_addr == 12'd2); i++) begin
            @(negedge clk);
            if (r_en && r_addr == 12'd2) nen = 1;
        end
        chk("p6_reach_row2", 64'(nen), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("p6_rst_strobes", 64'({r_sof, m_axis_fsync, r_en}), 0);
        chk("p6_rst_addr", 64'(r_addr), 0);
        chk("p6_rst_stream", 64'({m_axis_tvalid, m_axis_tuser, m_axis_tlast}), 0);
        chk("p6_rst_busy_ovr", 64'({busy, overrun}), 0);
        tick(6);
        salt = 8'd7; height = 12'd3; push_scan(8'd7, 3);
        pulse();
        first_en = -1;
        for (int i = 0; i < 10 && first_en < 0; i++) begin
            @(negedge clk);
            if (r_en) begin
                first_en = i;
                chk("p6_first_addr", 64'(r_addr), 0);
            end
        end
        chk("p6_read_started", 64'(first_en >= 0), 64'd1);
        wait_empty("p6_drain", 40);
        wait_idle("p6_idle", 20);

        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
